// File: rtl/umi_packet_split_if.sv
// UMI packet bundle: one valid/ready channel carrying cmd, addresses and data.
// The master drives the packet and the slave returns ready.
interface umi_packet_split_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;

    modport master (
        output valid, cmd, dstaddr, srcaddr, data,
        input  ready
    );

    modport slave (
        input  valid, cmd, dstaddr, srcaddr, data,
        output ready
    );
endinterface

// File: rtl/umi_packet_split.sv
// Splits one wide UMI packet into back-to-back narrow packets, recomputing
// len, eom and both addresses for every piece.
module umi_packet_split #(
    parameter int CW  = 32,
    parameter int AW  = 64,
    parameter int IDW = 128,
    parameter int ODW = 64
) (
    input  logic               clk,
    input  logic               nreset,
    umi_packet_split_if.slave  umi_in,
    umi_packet_split_if.master umi_out
);
    localparam int IB  = IDW / 8;
    localparam int OBI = ODW / 8;
    localparam int RW  = $clog2(IB) + 1;
    localparam logic [RW-1:0] OB = RW'(OBI);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_rst_done;
    logic [CW-1:0] r_cmd;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_src;
    logic [IDW-1:0] r_data;
    logic [RW-1:0] r_rem;
    logic          r_split;

    logic [4:0]    w_in_op;
    logic [2:0]    w_in_size;
    logic [7:0]    w_in_len;
    logic          w_in_ex;
    logic [15:0]   w_in_eb;
    logic [15:0]   w_in_bytes;
    logic          w_in_opok;
    logic          w_in_split;
    logic [RW-1:0] w_in_rem;

    logic [RW-1:0] w_chunk;
    logic [RW-1:0] w_beats;
    logic [7:0]    w_len;
    logic          w_last;
    logic [CW-1:0] w_out_cmd;
    logic [ODW-1:0] w_mask_data;
    logic [ODW-1:0] w_out_data;

    logic          w_in_ready;
    logic          w_in_commit;
    logic          w_out_valid;
    logic          w_out_commit;

    // Classify the incoming packet; byte count is clamped to the input width.
    always_comb begin
        w_in_op    = umi_in.cmd[4:0];
        w_in_size  = umi_in.cmd[7:5];
        w_in_len   = umi_in.cmd[15:8];
        w_in_ex    = umi_in.cmd[24];
        w_in_eb    = 16'd1 << w_in_size;
        w_in_bytes = w_in_eb * (16'(w_in_len) + 16'd1);
        w_in_rem   = (w_in_bytes > 16'(IB)) ? RW'(IB)
                                            : w_in_bytes[RW-1:0];
        w_in_opok  = (w_in_op == 5'h01) | (w_in_op == 5'h03) |
                     (w_in_op == 5'h05) | (w_in_op == 5'h07) |
                     (w_in_op == 5'h02) | (w_in_op == 5'h04);
        w_in_split = w_in_opok & ~w_in_ex &
                     (w_in_eb <= 16'(OBI)) &
                     (w_in_bytes > 16'(OBI));
    end

    always_comb begin
        w_chunk = (r_rem > OB) ? OB : r_rem;
        w_last  = ~r_split | (r_rem <= OB);
        w_beats = w_chunk >> r_cmd[7:5];
        w_len   = 8'(w_beats - RW'(1));
        w_out_cmd = r_cmd;
        if (r_split) begin
            w_out_cmd[15:8] = w_len;
            w_out_cmd[22]   = r_cmd[22] & w_last;
        end
        w_mask_data = '0;
        for (int i = 0; i < OBI; i++) begin
            if (RW'(i) < w_chunk)
                w_mask_data[i*8 +: 8] = r_data[i*8 +: 8];
        end
        w_out_data = r_split ? w_mask_data : r_data[ODW-1:0];
    end

    // Ready reopens on the final chunk's commit so packets stream without a bubble.
    assign w_out_valid  = (r_state == SEND);
    assign w_out_commit = w_out_valid & umi_out.ready;
    assign w_in_ready   = r_rst_done[1] &
                          ((r_state == IDLE) | (w_out_commit & w_last));
    assign w_in_commit  = umi_in.valid & w_in_ready;

    assign umi_in.ready    = w_in_ready;
    assign umi_out.valid   = w_out_valid;
    assign umi_out.cmd     = w_out_cmd;
    assign umi_out.dstaddr = r_dst;
    assign umi_out.srcaddr = r_src;
    assign umi_out.data    = w_out_data;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_in_commit)
                    w_state_nxt = SEND;
            end
            SEND: begin
                if (w_out_commit & w_last)
                    w_state_nxt = w_in_commit ? SEND : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_rst_done <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= {r_rst_done[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cmd   <= '0;
            r_dst   <= '0;
            r_src   <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_split <= 1'b0;
        end else if (w_in_commit) begin
            r_cmd   <= umi_in.cmd;
            r_dst   <= umi_in.dstaddr;
            r_src   <= umi_in.srcaddr;
            r_data  <= umi_in.data;
            r_rem   <= w_in_rem;
            r_split <= w_in_split;
        end else if (w_out_commit & ~w_last) begin
            r_dst  <= r_dst + AW'(w_chunk);
            r_src  <= r_src + AW'(w_chunk);
            r_data <= r_data >> {w_chunk, 3'b000};
            r_rem  <= r_rem - w_chunk;
        end
    end
endmodule
